// File: rtl/eth_rx_frame_buffer.sv
// RX payload buffer: filters on destination MAC, buffers each frame speculatively, commits or rewinds at frame end.
// First m_valid two edges after commit; m_valid/m_ready stream with a prefetch so back-to-back beats have no bubble.
module eth_rx_frame_buffer #(
   parameter int          ADDR_W       = 11,
   parameter int          META_DEPTH_W = 2,
   parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
   parameter bit          PROMISC      = 1'b0
) (
   input  logic              clk125,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              frame_done,
   input  logic              frame_error,
   input  logic [15:0]       ethertype,
   input  logic [47:0]       dest_mac,
   input  logic [7:0]        payload_data,
   input  logic              payload_valid,
   output logic [7:0]        m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [15:0]       m_ethertype,
   output logic [ADDR_W:0]   m_len,
   output logic [15:0]       drop_count,
   output logic              overflow
);

   localparam int                META_DEPTH = 1 << META_DEPTH_W;
   localparam int                META_W     = 16 + ADDR_W + 1;
   localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
   localparam logic [ADDR_W:0]   LEN_ONE    = 1;
   localparam logic [META_DEPTH_W:0] MPTR_ONE = 1;

   typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DISCARD} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

   wstate_t             w_state_q, w_state_d;
   rstate_t             r_state_q, r_state_d;
   logic [ADDR_W-1:0]   spec_ptr_q, spec_ptr_d, commit_ptr_q, commit_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, raddr_q, raddr_d, ram_raddr;
   logic [ADDR_W:0]     len_q, len_d, len_n, cnt_q, cnt_d, m_len_q, m_len_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d, m_eth_q, m_eth_d;
   logic [7:0]          m_data_q, m_data_d, ram_q;
   logic                m_valid_q, m_valid_d, m_last_q, m_last_d, ovf_q, ovf_d;
   logic                ram_we, meta_push, meta_pop, go_discard, drop, restart;
   logic                mac_ok, ram_full, meta_full, meta_empty;
   logic [META_DEPTH_W:0] meta_wp_q, meta_rp_q;

   logic [7:0]          mem [1 << ADDR_W];
   logic [META_W-1:0]   meta_mem [META_DEPTH];

   assign mac_ok     = PROMISC || (dest_mac == LOCAL_MAC) || (&dest_mac);
   // One slot stays empty so spec_ptr == rd_ptr always means "nothing buffered".
   assign ram_full   = (spec_ptr_q + PTR_ONE) == rd_ptr_q;
   assign meta_empty = meta_wp_q == meta_rp_q;
   assign meta_full  = (meta_wp_q[META_DEPTH_W] != meta_rp_q[META_DEPTH_W]) &&
                       (meta_wp_q[META_DEPTH_W-1:0] == meta_rp_q[META_DEPTH_W-1:0]);

   always_comb begin
      w_state_d    = w_state_q;
      spec_ptr_d   = spec_ptr_q;
      commit_ptr_d = commit_ptr_q;
      len_d        = len_q;
      len_n        = len_q;
      drop_cnt_d   = drop_cnt_q;
      ovf_d        = 1'b0;
      ram_we       = 1'b0;
      meta_push    = 1'b0;
      go_discard   = 1'b0;
      drop         = 1'b0;
      restart      = 1'b0;
      case (w_state_q)
         W_IDLE: restart = frame_start;
         W_ACCEPT: begin
            if (frame_start) begin
               drop    = 1'b1;
               restart = 1'b1;
            end else if (frame_error) begin
               drop = 1'b1;
            end else begin
               // A byte arriving with frame_done is written first and counts toward the commit.
               if (payload_valid) begin
                  if (len_q == '0 && !mac_ok) begin
                     go_discard = 1'b1;
                  end else if (ram_full) begin
                     go_discard = 1'b1;
                     ovf_d      = 1'b1;
                  end else begin
                     ram_we     = 1'b1;
                     spec_ptr_d = spec_ptr_q + PTR_ONE;
                     len_n      = len_q + LEN_ONE;
                  end
               end
               len_d = len_n;
               if (frame_done) begin
                  if (go_discard || len_n == '0) begin
                     drop = 1'b1;
                  end else if (meta_full) begin
                     drop  = 1'b1;
                     ovf_d = 1'b1;
                  end else begin
                     commit_ptr_d = spec_ptr_d;
                     meta_push    = 1'b1;
                     w_state_d    = W_IDLE;
                  end
               end else if (go_discard) begin
                  w_state_d = W_DISCARD;
               end
            end
         end
         W_DISCARD: begin
            drop    = frame_start | frame_done | frame_error;
            restart = frame_start;
         end
         default: w_state_d = W_IDLE;
      endcase
      if (drop) begin
         spec_ptr_d = commit_ptr_q;
         w_state_d  = W_IDLE;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      if (restart) begin
         spec_ptr_d = commit_ptr_q;
         len_d      = '0;
         w_state_d  = W_ACCEPT;
      end
   end

   // raddr_q is the address whose byte sits in ram_q, one ahead of the presented byte.
   always_comb begin
      r_state_d = r_state_q;
      rd_ptr_d  = rd_ptr_q;
      raddr_d   = raddr_q;
      cnt_d     = cnt_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_eth_d   = m_eth_q;
      m_len_d   = m_len_q;
      meta_pop  = 1'b0;
      ram_raddr = raddr_q;
      case (r_state_q)
         R_IDLE: begin
            if (!meta_empty) begin
               meta_pop           = 1'b1;
               {m_eth_d, m_len_d} = meta_mem[meta_rp_q[META_DEPTH_W-1:0]];
               ram_raddr          = rd_ptr_q;
               raddr_d            = rd_ptr_q;
               r_state_d          = R_LOAD;
            end
         end
         R_LOAD: begin
            m_data_d  = ram_q;
            m_valid_d = 1'b1;
            m_last_d  = (m_len_q == LEN_ONE);
            cnt_d     = LEN_ONE;
            ram_raddr = raddr_q + PTR_ONE;
            raddr_d   = raddr_q + PTR_ONE;
            r_state_d = R_STREAM;
         end
         R_STREAM: begin
            if (m_valid_q && m_ready) begin
               if (m_last_q) begin
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
                  rd_ptr_d  = rd_ptr_q + m_len_q[ADDR_W-1:0];
                  r_state_d = R_IDLE;
               end else begin
                  m_data_d  = ram_q;
                  cnt_d     = cnt_q + LEN_ONE;
                  m_last_d  = ((cnt_q + LEN_ONE) == m_len_q);
                  ram_raddr = raddr_q + PTR_ONE;
                  raddr_d   = raddr_q + PTR_ONE;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk125) begin
      if (ram_we) mem[spec_ptr_q] <= payload_data;
      ram_q <= mem[ram_raddr];
      if (meta_push) meta_mem[meta_wp_q[META_DEPTH_W-1:0]] <= {ethertype, len_n};
   end

   always_ff @(posedge clk125) begin
      if (rst) begin
         w_state_q    <= W_IDLE;
         r_state_q    <= R_IDLE;
         spec_ptr_q   <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         raddr_q      <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         drop_cnt_q   <= '0;
         ovf_q        <= 1'b0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         m_eth_q      <= '0;
         m_len_q      <= '0;
         meta_wp_q    <= '0;
         meta_rp_q    <= '0;
      end else begin
         w_state_q    <= w_state_d;
         r_state_q    <= r_state_d;
         spec_ptr_q   <= spec_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         raddr_q      <= raddr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         ovf_q        <= ovf_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         m_eth_q      <= m_eth_d;
         m_len_q      <= m_len_d;
         if (meta_push) meta_wp_q <= meta_wp_q + MPTR_ONE;
         if (meta_pop)  meta_rp_q <= meta_rp_q + MPTR_ONE;
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign m_ethertype = m_eth_q;
   assign m_len       = m_len_q;
   assign drop_count  = drop_cnt_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Directed + randomized bench for eth_rx_frame_buffer with a frame-level scoreboard.
module tb_eth_rx_frame_buffer;
   localparam int          ADDR_W    = 11;
   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
   localparam int          CAP       = (1 << ADDR_W) - 1;
   localparam int          FRAME_SLOTS = 5;

   logic              clk125 = 1'b0;
   logic              rst = 1'b1;
   logic              frame_start = 1'b0, frame_done = 1'b0, frame_error = 1'b0;
   logic [15:0]       ethertype = '0;
   logic [47:0]       dest_mac = '0;
   logic [7:0]        payload_data = '0;
   logic              payload_valid = 1'b0;
   logic [7:0]        m_data;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic              m_last;
   logic [15:0]       m_ethertype;
   logic [ADDR_W:0]   m_len;
   logic [15:0]       drop_count;
   logic              overflow;

   eth_rx_frame_buffer #(.ADDR_W(ADDR_W), .META_DEPTH_W(2), .LOCAL_MAC(LOCAL_MAC), .PROMISC(1'b0)) dut (
      .clk125(clk125), .rst(rst), .frame_start(frame_start), .frame_done(frame_done),
      .frame_error(frame_error), .ethertype(ethertype), .dest_mac(dest_mac),
      .payload_data(payload_data), .payload_valid(payload_valid), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_ethertype(m_ethertype),
      .m_len(m_len), .drop_count(drop_count), .overflow(overflow));

   always #4 clk125 = ~clk125;

   typedef struct packed {
      logic [15:0] eth;
      int          len;
   } frm_t;

   int   checks = 0, failures = 0;
   frm_t exp_frames[$];
   logic [7:0] exp_bytes[$];
   int   used_m = 0, outstanding_m = 0, drops_m = 0, ovf_m = 0, ovf_seen = 0;
   int   cur_idx = 1;
   int   rdy_mode = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk125) begin
      if (rst) begin
         cur_idx = 1;
      end else begin
         if (overflow) ovf_seen++;
         if (m_valid) begin
            if (exp_frames.size() == 0) begin
               chk("unexpected_beat", 64'(m_valid), 64'd0);
            end else begin
               chk("m_data", 64'(m_data), 64'(exp_bytes[0]));
               chk("m_last", 64'(m_last), 64'(cur_idx == exp_frames[0].len));
               chk("m_len", 64'(m_len), 64'(exp_frames[0].len));
               chk("m_ethertype", 64'(m_ethertype), 64'(exp_frames[0].eth));
               if (m_ready) begin
                  void'(exp_bytes.pop_front());
                  cur_idx++;
                  if (cur_idx > exp_frames[0].len) begin
                     void'(exp_frames.pop_front());
                     cur_idx = 1;
                  end
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk125);
      #1;
      case (rdy_mode)
         1: m_ready = ~m_ready;
         2: m_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   // kind: 0 done with last byte, 1 done on a later cycle, 2 error+done with last byte, 3 no done
   task automatic send_frame(input int len, input logic [47:0] mac, input logic [15:0] eth,
                             input int kind, input bit gaps);
      logic [7:0] b;
      logic [7:0] bytes[$];
      frm_t f;
      bit mac_ok;
      frame_start = 1'b1; dest_mac = mac; ethertype = eth;
      cyc();
      frame_start = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            payload_valid = 1'b0;
            cyc();
         end
         b = 8'($urandom);
         bytes.push_back(b);
         payload_valid = 1'b1; payload_data = b;
         if (i == len - 1 && (kind == 0 || kind == 2)) begin
            frame_done = 1'b1; frame_error = (kind == 2);
         end
         cyc();
      end
      payload_valid = 1'b0; frame_done = 1'b0; frame_error = 1'b0;
      if (kind == 1 || (len == 0 && kind != 3)) begin
         frame_done = 1'b1; frame_error = (kind == 2);
         cyc();
         frame_done = 1'b0; frame_error = 1'b0;
      end
      mac_ok = (mac == LOCAL_MAC) || (mac == BCAST);
      if (kind >= 2 || !mac_ok || len == 0) begin
         drops_m++;
      end else if (used_m + len > CAP || outstanding_m >= FRAME_SLOTS) begin
         drops_m++; ovf_m++;
      end else begin
         used_m += len; outstanding_m++;
         f.eth = eth; f.len = len;
         exp_frames.push_back(f);
         foreach (bytes[i]) exp_bytes.push_back(bytes[i]);
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_frames.size() != 0 && n < 20000) begin
         cyc(); n++;
      end
      chk({tag, "_drained"}, 64'(exp_frames.size()), 64'd0);
      repeat (3) cyc();
      used_m = 0; outstanding_m = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [47:0] mac;
      int kind;
      repeat (3) cyc();
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_m_len", 64'(m_len), 64'd0);
      chk("rst_m_eth", 64'(m_ethertype), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      rst = 1'b0;
      cyc();

      // 64-byte unicast frame and first-beat latency
      m_ready = 1'b1;
      send_frame(64, LOCAL_MAC, 16'h0800, 0, 1'b0);
      chk("lat_edge0", 64'(m_valid), 64'd0);
      cyc();
      chk("lat_edge1", 64'(m_valid), 64'd0);
      cyc();
      chk("lat_edge2", 64'(m_valid), 64'd1);
      chk("t1_len", 64'(m_len), 64'd64);
      chk("t1_eth", 64'(m_ethertype), 64'h0800);
      wait_drain("t1");
      chk("t1_drop", 64'(drop_count), 64'(drops_m));

      // broadcast accepted, foreign unicast filtered
      send_frame(46, BCAST, 16'h86DD, 0, 1'b0);
      send_frame(20, OTHER_MAC, 16'h0800, 0, 1'b0);
      wait_drain("t2");
      chk("t2_drop", 64'(drop_count), 64'(drops_m));

      // error with done rewinds; following frame reuses the same space
      send_frame(100, LOCAL_MAC, 16'h0800, 2, 1'b0);
      send_frame(10, LOCAL_MAC, 16'h0806, 0, 1'b0);
      wait_drain("t3");
      chk("t3_drop", 64'(drop_count), 64'(drops_m));

      // empty frame, then a frame cut short by the next frame_start
      send_frame(0, LOCAL_MAC, 16'h0800, 0, 1'b0);
      send_frame(30, LOCAL_MAC, 16'h0800, 3, 1'b0);
      send_frame(15, LOCAL_MAC, 16'h0801, 1, 1'b1);
      wait_drain("t3b");
      chk("t3b_drop", 64'(drop_count), 64'(drops_m));

      // RAM fills while downstream stalls
      m_ready = 1'b0;
      repeat (6) send_frame(500, LOCAL_MAC, 16'h88B5, 0, 1'b0);
      repeat (4) cyc();
      chk("t4_ovf_pulses", 64'(ovf_seen), 64'(ovf_m));
      chk("t4_drop", 64'(drop_count), 64'(drops_m));
      chk("t4_stalled_valid", 64'(m_valid), 64'd1);
      m_ready = 1'b1;
      wait_drain("t4");

      // randomized batches with throttled ready, crossing the pointer wrap
      rdy_mode = 1;
      for (int bt = 0; bt < 12; bt++) begin
         if (bt == 6) rdy_mode = 2;
         for (int f = 0; f < 3; f++) begin
            case ($urandom_range(0, 3))
               0, 1: mac = LOCAL_MAC;
               2: mac = BCAST;
               default: mac = OTHER_MAC;
            endcase
            kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            send_frame(int'($urandom_range(1, 250)), mac, 16'($urandom), kind, bit'(bt % 2));
         end
         wait_drain("t5");
      end
      rdy_mode = 0;
      m_ready = 1'b1;
      chk("t5_drop", 64'(drop_count), 64'(drops_m));

      // reset in the middle of a frame
      frame_start = 1'b1; dest_mac = LOCAL_MAC; ethertype = 16'h0800;
      cyc();
      frame_start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         payload_valid = 1'b1; payload_data = 8'($urandom);
         cyc();
      end
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      chk("t6_rst_drop", 64'(drop_count), 64'd0);
      chk("t6_rst_valid", 64'(m_valid), 64'd0);
      for (int i = 0; i < 30; i++) begin
         payload_valid = 1'b1; payload_data = 8'($urandom);
         frame_done = (i == 29);
         cyc();
      end
      payload_valid = 1'b0; frame_done = 1'b0;
      drops_m = 0; used_m = 0; outstanding_m = 0;
      repeat (4) cyc();
      chk("t6_idle_valid", 64'(m_valid), 64'd0);
      send_frame(12, LOCAL_MAC, 16'h0800, 0, 1'b1);
      wait_drain("t6");
      chk("t6_drop", 64'(drop_count), 64'd0);
      chk("final_ovf", 64'(ovf_seen), 64'(ovf_m));
      chk("final_bytes_left", 64'(exp_bytes.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
